// File: rtl/dm_multihart_ctrl_pkg.sv
// Shared definitions for the multi-hart debug-module control core:
// register map, DMI op/response codes, field offsets and the resume FSM states.
package dm_pkg;

  localparam logic [6:0] ADDR_DMCONTROL   = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS    = 7'h11;
  localparam logic [6:0] ADDR_HAWINDOWSEL = 7'h14;
  localparam logic [6:0] ADDR_HAWINDOW    = 7'h15;
  localparam logic [6:0] ADDR_HALTSUM0    = 7'h40;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSVD  = 2'd3
  } dmiOp_e;

  typedef enum logic [1:0] {
    RESP_OK     = 2'd0,
    RESP_FAILED = 2'd2
  } dmiResp_e;

  localparam int DMC_HALTREQ    = 31;
  localparam int DMC_RESUMEREQ  = 30;
  localparam int DMC_HASEL      = 26;
  localparam int DMC_HARTSELLO  = 16;
  localparam int DMC_HARTSELHI  = 6;
  localparam int DMC_NDMRESET   = 1;
  localparam int DMC_DMACTIVE   = 0;
  localparam int HARTSEL_FIELD  = 10;

  localparam int DMS_ALLRESUMEACK = 17;
  localparam int DMS_ANYRESUMEACK = 16;
  localparam int DMS_ALLNONEXIST  = 15;
  localparam int DMS_ANYNONEXIST  = 14;
  localparam int DMS_ALLRUNNING   = 11;
  localparam int DMS_ANYRUNNING   = 10;
  localparam int DMS_ALLHALTED    = 9;
  localparam int DMS_ANYHALTED    = 8;
  localparam int DMS_AUTH         = 7;
  localparam logic [3:0] DM_VERSION = 4'd2;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    ACKED
  } resumeState_e;

endpackage

// File: rtl/dm_multihart_ctrl_if.sv
// DMI request/response channel between the JTAG-side transport (master)
// and the debug-module control core (slave).
interface dm_multihart_ctrl_if;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [1:0]  dmi_req_op;
  logic [31:0] dmi_req_data;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready;
  logic [31:0] dmi_resp_data;
  logic [1:0]  dmi_resp_resp;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready,
    input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp
  );

  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready,
    output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp
  );
endinterface

// File: rtl/dm_multihart_ctrl_resume_fsm.sv
// Per-hart resume handshake: a resume request is raised on a go to a halted
// hart and retired into the acknowledged state by the hart's resumeack pulse.
module dm_hart_resume_fsm
  import dm_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic go,
  input  logic halted,
  input  logic resumeack,
  input  logic clear,
  output logic resumereq,
  output logic acked
);

  resumeState_e stateReg, stateNext;

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // A fresh go outranks an ack arriving in the same cycle.
  always_comb begin
    stateNext = stateReg;
    resumereq = 1'b0;
    acked     = 1'b0;
    if (clear) begin
      stateNext = IDLE;
    end else if (go && halted) begin
      stateNext = PENDING;
    end else begin
      case (stateReg)
        PENDING: if (resumeack) stateNext = ACKED;
        default: ;
      endcase
    end
    resumereq = (stateReg == PENDING);
    acked     = (stateReg == ACKED);
  end

endmodule

// File: rtl/dm_multihart_ctrl.sv
// Debug-module control core for NHARTS harts: DMI front end, dmcontrol /
// hawindow registers, per-hart halt/resume requests and dmstatus reduction.
module dm_multihart_ctrl
  import dm_pkg::*;
#(
  parameter int NHARTS     = 4,
  parameter int HARTSELLEN = 5
) (
  input  logic              clock,
  input  logic              reset,
  dm_multihart_ctrl_if.slave dmi,
  output logic [NHARTS-1:0] hart_haltreq,
  output logic [NHARTS-1:0] hart_resumereq,
  input  logic [NHARTS-1:0] hart_halted,
  input  logic [NHARTS-1:0] hart_resumeack,
  output logic              dmactive,
  output logic              ndmreset
);

  logic                  dmactiveReg, ndmresetReg, haselReg;
  logic [HARTSELLEN-1:0] hartselReg;
  logic [NHARTS-1:0]     hawindowReg, haltreqReg;
  logic                  respValidReg;
  logic [31:0]           respDataReg;
  dmiResp_e              respRespReg;

  dmiOp_e                reqOp;
  logic                  accept, ctrlAccess, ctrlWrite, deactivate, clearAll;
  logic [19:0]           wrHartselFull, hartselFull;
  logic [HARTSELLEN-1:0] wrHartsel;
  logic [NHARTS-1:0]     curSel, wrSel, resumeGo, ackedV;
  logic                  hartselMissing;
  logic [31:0]           statusWord, readData;
  logic                  unusedBits;

  assign reqOp       = dmiOp_e'(dmi.dmi_req_op);
  assign accept      = dmi.dmi_req_valid & ~respValidReg;
  assign ctrlAccess  = accept & (reqOp == DMI_WRITE) & (dmi.dmi_req_addr == ADDR_DMCONTROL);
  assign ctrlWrite   = ctrlAccess & dmactiveReg & dmi.dmi_req_data[DMC_DMACTIVE];
  assign deactivate  = ctrlAccess & ~dmi.dmi_req_data[DMC_DMACTIVE];
  assign clearAll    = ~dmactiveReg | deactivate;

  assign wrHartselFull = {dmi.dmi_req_data[DMC_HARTSELHI +: HARTSEL_FIELD],
                          dmi.dmi_req_data[DMC_HARTSELLO +: HARTSEL_FIELD]};
  assign wrHartsel     = wrHartselFull[HARTSELLEN-1:0];
  assign hartselFull   = 20'(hartselReg);
  assign hartselMissing = 32'(hartselReg) >= 32'(NHARTS);
  assign unusedBits    = ^{dmi.dmi_req_data, wrHartselFull};

  // The write's own hartsel/hasel pick the harts it acts on.
  assign resumeGo = wrSel & {NHARTS{ctrlWrite & dmi.dmi_req_data[DMC_RESUMEREQ]
                                    & ~dmi.dmi_req_data[DMC_HALTREQ]}};

  for (genvar gi = 0; gi < NHARTS; gi++) begin : g_hart
    assign curSel[gi] = (hartselReg == HARTSELLEN'(gi)) | (haselReg & hawindowReg[gi]);
    assign wrSel[gi]  = (wrHartsel == HARTSELLEN'(gi))
                      | (dmi.dmi_req_data[DMC_HASEL] & hawindowReg[gi]);

    dm_hart_resume_fsm u_resume (
      .clock     (clock),
      .reset     (reset),
      .go        (resumeGo[gi]),
      .halted    (hart_halted[gi]),
      .resumeack (hart_resumeack[gi]),
      .clear     (clearAll),
      .resumereq (hart_resumereq[gi]),
      .acked     (ackedV[gi])
    );
  end

  function automatic logic [1:0] allAny(input logic [NHARTS-1:0] flags,
                                        input logic [NHARTS-1:0] sel,
                                        input logic              noneMissing);
    allAny = {(|sel) & noneMissing & ((flags & sel) == sel), |(flags & sel)};
  endfunction

  always_comb begin
    statusWord = '0;
    statusWord[3:0]      = DM_VERSION;
    statusWord[DMS_AUTH] = 1'b1;
    if (dmactiveReg) begin
      statusWord[DMS_ALLRESUMEACK:DMS_ANYRESUMEACK] = allAny(ackedV, curSel, ~hartselMissing);
      statusWord[DMS_ALLNONEXIST]  = hartselMissing & ~|(curSel);
      statusWord[DMS_ANYNONEXIST]  = hartselMissing;
      statusWord[DMS_ALLRUNNING:DMS_ANYRUNNING] = allAny(~hart_halted, curSel, ~hartselMissing);
      statusWord[DMS_ALLHALTED:DMS_ANYHALTED]   = allAny(hart_halted, curSel, ~hartselMissing);
    end
  end

  always_comb begin
    readData = '0;
    case (dmi.dmi_req_addr)
      ADDR_DMCONTROL: begin
        readData[DMC_DMACTIVE] = dmactiveReg;
        readData[DMC_NDMRESET] = ndmresetReg;
        readData[DMC_HASEL]    = haselReg;
        readData[DMC_HARTSELLO +: HARTSEL_FIELD] = hartselFull[9:0];
        readData[DMC_HARTSELHI +: HARTSEL_FIELD] = hartselFull[19:10];
      end
      ADDR_DMSTATUS:    readData = statusWord;
      ADDR_HAWINDOWSEL: readData = '0;
      ADDR_HAWINDOW:    readData = 32'(hawindowReg);
      ADDR_HALTSUM0:    readData = dmactiveReg ? 32'(hart_halted) : '0;
      default:          readData = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      respValidReg <= 1'b0;
      respDataReg  <= '0;
      respRespReg  <= RESP_OK;
      dmactiveReg  <= 1'b0;
      ndmresetReg  <= 1'b0;
      haselReg     <= 1'b0;
      hartselReg   <= '0;
      hawindowReg  <= '0;
      haltreqReg   <= '0;
    end else begin
      if (respValidReg && dmi.dmi_resp_ready) begin
        respValidReg <= 1'b0;
      end
      if (accept) begin
        respValidReg <= 1'b1;
        respDataReg  <= (reqOp == DMI_READ) ? readData : '0;
        respRespReg  <= (reqOp == DMI_RSVD) ? RESP_FAILED : RESP_OK;
      end
      if (ctrlAccess) begin
        dmactiveReg <= dmi.dmi_req_data[DMC_DMACTIVE];
      end
      if (clearAll) begin
        ndmresetReg <= 1'b0;
        haselReg    <= 1'b0;
        hartselReg  <= '0;
        hawindowReg <= '0;
        haltreqReg  <= '0;
      end else begin
        if (ctrlWrite) begin
          ndmresetReg <= dmi.dmi_req_data[DMC_NDMRESET];
          haselReg    <= dmi.dmi_req_data[DMC_HASEL];
          hartselReg  <= wrHartsel;
          haltreqReg  <= (haltreqReg & ~wrSel)
                       | (wrSel & {NHARTS{dmi.dmi_req_data[DMC_HALTREQ]}});
        end
        if (accept && reqOp == DMI_WRITE && dmi.dmi_req_addr == ADDR_HAWINDOW) begin
          hawindowReg <= dmi.dmi_req_data[NHARTS-1:0];
        end
      end
    end
  end

  assign dmi.dmi_req_ready  = ~respValidReg;
  assign dmi.dmi_resp_valid = respValidReg;
  assign dmi.dmi_resp_data  = respDataReg;
  assign dmi.dmi_resp_resp  = respRespReg;
  assign hart_haltreq       = haltreqReg;
  assign dmactive           = dmactiveReg;
  assign ndmreset           = ndmresetReg;

endmodule

// File: tb/tb_dm_multihart_ctrl.sv
// Randomised DMI traffic against a register-level model of the multi-hart
// debug-module control core, plus directed halt/resume/window/stall scenarios.
module tb_dm_multihart_ctrl;

  localparam int NH  = 4;
  localparam int HSL = 5;

  logic          clock;
  logic          reset;
  logic [NH-1:0] hart_haltreq, hart_resumereq;
  logic [NH-1:0] hartHalted, hartResumeack;
  logic          dmactive, ndmreset;

  dm_multihart_ctrl_if dmi();

  dm_multihart_ctrl #(.NHARTS(NH), .HARTSELLEN(HSL)) dut (
    .clock          (clock),
    .reset          (reset),
    .dmi            (dmi),
    .hart_haltreq   (hart_haltreq),
    .hart_resumereq (hart_resumereq),
    .hart_halted    (hartHalted),
    .hart_resumeack (hartResumeack),
    .dmactive       (dmactive),
    .ndmreset       (ndmreset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: architectural register contents and per-hart resume flags.
  bit          mActive, mNdm, mHasel;
  int          mHartsel;
  bit [NH-1:0] mWindow, mHaltreq, mPending, mAcked;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic void resetModel();
    mActive = 0; mNdm = 0; mHasel = 0; mHartsel = 0;
    mWindow = '0; mHaltreq = '0; mPending = '0; mAcked = '0;
  endfunction

  function automatic bit isSelected(input int i, input int hs, input bit hasel);
    return (hs == i) || (hasel && mWindow[i]);
  endfunction

  function automatic logic [31:0] modelRead(input logic [6:0] a);
    logic [31:0] v;
    int nSel, nHalt, nRun, nAck;
    bit nonEx;
    v = '0; nSel = 0; nHalt = 0; nRun = 0; nAck = 0;
    case (a)
      7'h10: if (mActive)
        v = 32'h1 | (32'(mNdm) << 1) | (32'(mHasel) << 26)
          | (32'(mHartsel & 'h3ff) << 16) | (32'((mHartsel >> 10) & 'h3ff) << 6);
      7'h11: begin
        v = 32'h82;
        if (mActive) begin
          for (int i = 0; i < NH; i++) begin
            if (isSelected(i, mHartsel, mHasel)) begin
              nSel++;
              if (hartHalted[i]) nHalt++; else nRun++;
              if (mAcked[i]) nAck++;
            end
          end
          nonEx = (mHartsel >= NH);
          v[17] = (nSel > 0) && !nonEx && (nAck == nSel);
          v[16] = (nAck > 0);
          v[15] = nonEx && (nSel == 0);
          v[14] = nonEx;
          v[11] = (nSel > 0) && !nonEx && (nRun == nSel);
          v[10] = (nRun > 0);
          v[9]  = (nSel > 0) && !nonEx && (nHalt == nSel);
          v[8]  = (nHalt > 0);
        end
      end
      7'h15: v = 32'(mWindow);
      7'h40: if (mActive) v = 32'(hartHalted);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void modelAck(input logic [NH-1:0] ack);
    for (int i = 0; i < NH; i++)
      if (ack[i] && mPending[i]) begin mPending[i] = 0; mAcked[i] = 1; end
  endfunction

  function automatic void modelWrite(input logic [6:0] a, input logic [31:0] d);
    if (a == 7'h10) begin
      if (!mActive) mActive = d[0];
      else if (!d[0]) resetModel();
      else begin
        mNdm = d[1];
        mHasel = d[26];
        mHartsel = ((int'(d[15:6]) << 10) | int'(d[25:16])) % (1 << HSL);
        for (int i = 0; i < NH; i++) begin
          if (isSelected(i, mHartsel, mHasel)) begin
            mHaltreq[i] = d[31];
            if (d[30] && !d[31] && hartHalted[i]) begin mPending[i] = 1; mAcked[i] = 0; end
          end
        end
      end
    end else if (a == 7'h15 && mActive) begin
      mWindow = d[NH-1:0];
    end
  endfunction

  // One DMI transaction; 'ack' is pulsed on hart_resumeack at the accept edge.
  task automatic doOp(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                      input logic [NH-1:0] ack, output logic [31:0] rd);
    logic [31:0] expData;
    logic [1:0]  expResp;
    bit          got;
    if (ack != '0) begin @(posedge clock); #1; end
    expResp = (op == 2'd3) ? 2'd2 : 2'd0;
    expData = (op == 2'd1) ? modelRead(a) : 32'd0;
    dmi.dmi_req_addr  = a;
    dmi.dmi_req_op    = op;
    dmi.dmi_req_data  = d;
    dmi.dmi_req_valid = 1'b1;
    hartResumeack     = ack;
    got = 0;
    for (int w = 0; w < 6 && !got; w++) begin
      @(posedge clock); #1;
      hartResumeack = '0;
      if (dmi.dmi_resp_valid) got = 1;
    end
    dmi.dmi_req_valid = 1'b0;
    rd = dmi.dmi_resp_data;
    $display("op=%0d addr=%02h wdata=%08h ack=%b rdata=%08h resp=%0d haltreq=%b resumereq=%b",
             op, a, d, ack, dmi.dmi_resp_data, dmi.dmi_resp_resp, hart_haltreq, hart_resumereq);
    checkVal("resp_valid", 32'(got), 32'd1);
    checkVal($sformatf("rdata@%02h", a), dmi.dmi_resp_data, expData);
    checkVal("resp_code", 32'(dmi.dmi_resp_resp), 32'(expResp));
    modelAck(ack);
    if (op == 2'd2) modelWrite(a, d);
    checkVal("haltreq", 32'(hart_haltreq), 32'(mHaltreq));
    checkVal("resumereq", 32'(hart_resumereq), 32'(mPending));
    checkVal("dmactive", 32'(dmactive), 32'(mActive));
    checkVal("ndmreset", 32'(ndmreset), 32'(mNdm));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d, held, expData;
    logic [6:0]  a;
    logic [1:0]  op;
    logic [NH-1:0] ack;

    dmi.dmi_req_valid = 0; dmi.dmi_req_addr = '0; dmi.dmi_req_op = '0;
    dmi.dmi_req_data = '0; dmi.dmi_resp_ready = 1;
    hartHalted = '0; hartResumeack = '0;
    reset = 1;
    resetModel();
    repeat (3) @(posedge clock);
    #1;
    checkVal("rst_resp_valid", 32'(dmi.dmi_resp_valid), 0);
    checkVal("rst_req_ready", 32'(dmi.dmi_req_ready), 1);
    checkVal("rst_hart_outs", 32'({hart_haltreq, hart_resumereq, dmactive, ndmreset}), 0);
    reset = 0;

    // Reset state read of dmstatus
    doOp(7'h11, 2'd1, 0, '0, rd);
    checkVal("t1_dmstatus", rd, 32'h82);

    // Halt hart 0
    doOp(7'h10, 2'd2, 32'h1, '0, rd);
    doOp(7'h10, 2'd2, 32'h8000_0001, '0, rd);
    checkVal("t2_haltreq", 32'(hart_haltreq), 32'h1);
    hartHalted = 4'b0001;
    doOp(7'h11, 2'd1, 0, '0, rd);
    checkVal("t2_allany_halted", 32'(rd[9:8]), 32'h3);

    // Resume hart 0, then ack
    doOp(7'h10, 2'd2, 32'h4000_0001, '0, rd);
    checkVal("t3_resumereq", 32'(hart_resumereq), 32'h1);
    hartHalted = 4'b0000;
    doOp(7'h10, 2'd0, 0, 4'b0001, rd);
    checkVal("t3_resumereq_done", 32'(hart_resumereq), 32'h0);
    doOp(7'h11, 2'd1, 0, '0, rd);
    checkVal("t3_resumeack_running", 32'({rd[17], rd[11]}), 32'h3);

    // Resume write coinciding with an ack pulse stays pending
    hartHalted = 4'b0001;
    doOp(7'h10, 2'd2, 32'h4000_0001, '0, rd);
    doOp(7'h10, 2'd2, 32'h4000_0001, 4'b0001, rd);
    checkVal("t3_write_wins", 32'(hart_resumereq), 32'h1);
    doOp(7'h10, 2'd0, 0, 4'b0001, rd);

    // Hart-array window
    doOp(7'h15, 2'd2, 32'hB, '0, rd);
    doOp(7'h10, 2'd2, 32'h8400_0001, '0, rd);
    checkVal("t4_window_haltreq", 32'(hart_haltreq), 32'hB);

    // Nonexistent hartsel
    doOp(7'h10, 2'd2, 32'h0007_0001, '0, rd);
    doOp(7'h11, 2'd1, 0, '0, rd);
    checkVal("t5_nonexistent", 32'(rd[15:14]), 32'h3);
    doOp(7'h10, 2'd2, 32'h8007_0001, '0, rd);
    checkVal("t5_haltreq_unchanged", 32'(hart_haltreq), 32'hB);

    // Deactivation clears state; writes while inactive are ignored
    doOp(7'h10, 2'd2, 32'h0, '0, rd);
    checkVal("t7_cleared", 32'(hart_haltreq), 32'h0);
    doOp(7'h15, 2'd2, 32'hF, '0, rd);
    doOp(7'h15, 2'd1, 0, '0, rd);
    checkVal("t7_window_inactive", rd, 32'h0);
    doOp(7'h10, 2'd2, 32'h1, '0, rd);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 7'h10;
        4, 5:       a = 7'h11;
        6:          a = 7'h15;
        7:          a = 7'h40;
        8:          a = 7'h14;
        default:    a = 7'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:             op = 2'd0;
        1, 2, 3, 4:    op = 2'd1;
        5, 6, 7, 8:    op = 2'd2;
        default:       op = 2'd3;
      endcase
      d = $urandom;
      if (a == 7'h10) begin
        d[0] = ($urandom_range(0, 9) != 0);
        d[25:16] = 10'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) d[15:6] = '0;
      end
      ack = ($urandom_range(0, 3) == 0) ? NH'($urandom) : '0;
      doOp(a, op, d, ack, rd);
      if ($urandom_range(0, 2) == 0) hartHalted = NH'($urandom);
    end

    // Response stall and reset during the stall
    @(posedge clock); #1;
    dmi.dmi_resp_ready = 0;
    expData = modelRead(7'h11);
    dmi.dmi_req_addr = 7'h11; dmi.dmi_req_op = 2'd1; dmi.dmi_req_valid = 1;
    @(posedge clock); #1;
    dmi.dmi_req_valid = 0;
    checkVal("stall_accept", 32'(dmi.dmi_resp_valid), 1);
    checkVal("stall_data0", dmi.dmi_resp_data, expData);
    held = dmi.dmi_resp_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      checkVal("stall_valid", 32'(dmi.dmi_resp_valid), 1);
      checkVal("stall_data", dmi.dmi_resp_data, held);
      checkVal("stall_req_ready", 32'(dmi.dmi_req_ready), 0);
    end
    reset = 1;
    @(posedge clock); #1;
    checkVal("midrst_resp_valid", 32'(dmi.dmi_resp_valid), 0);
    checkVal("midrst_outs", 32'({hart_haltreq, hart_resumereq, dmactive, ndmreset}), 0);
    reset = 0;
    resetModel();
    dmi.dmi_resp_ready = 1;
    doOp(7'h10, 2'd3, 32'h1, '0, rd);
    checkVal("op3_no_effect", 32'(dmactive), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
